// File: rtl/xor_arb_pkg.sv
// rtl/xor_arb_pkg.sv - shared FSM state type and default width for the parity arbiter
package xor_arb_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xor_bit_cell.sv
// rtl/xor_bit_cell.sv - single-bit XOR combine used by the parity accumulator
module xor_bit_cell (
    input  logic A,
    input  logic B,
    output logic F
);

    assign F = A ^ B;

endmodule

// File: rtl/xor_parity_arbiter.sv
// rtl/xor_parity_arbiter.sv - two-requester round-robin arbiter computing bit-serial parity of the granted word
module xor_parity_arbiter
    import xor_arb_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ0,
    input  logic [W-1:0] DATA0,
    input  logic         REQ1,
    input  logic [W-1:0] DATA1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         BUSY,
    output logic         DONE,
    output logic         PAR,
    output logic         OWNER
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_next;
    logic          acc;
    logic          acc_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          last;
    logic          last_next;
    logic          owner_int;
    logic          owner_int_next;
    logic          gnt0_next;
    logic          gnt1_next;
    logic          busy_next;
    logic          done_next;
    logic          par_next;
    logic          owner_next;
    logic          bit_f;
    logic          winner;

    xor_bit_cell u_bit (
        .A (acc),
        .B (shreg[0]),
        .F (bit_f)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            shreg     <= '0;
            acc       <= 1'b0;
            cnt       <= '0;
            last      <= 1'b1;
            owner_int <= 1'b0;
            GNT0      <= 1'b0;
            GNT1      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PAR       <= 1'b0;
            OWNER     <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            last      <= last_next;
            owner_int <= owner_int_next;
            GNT0      <= gnt0_next;
            GNT1      <= gnt1_next;
            BUSY      <= busy_next;
            DONE      <= done_next;
            PAR       <= par_next;
            OWNER     <= owner_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (REQ0 || REQ1) state_next = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered alongside the state.
    always_comb begin
        shreg_next     = shreg;
        acc_next       = acc;
        cnt_next       = cnt;
        last_next      = last;
        owner_int_next = owner_int;
        gnt0_next      = 1'b0;
        gnt1_next      = 1'b0;
        busy_next      = (state_next != S_IDLE);
        done_next      = 1'b0;
        par_next       = PAR;
        owner_next     = OWNER;
        winner         = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    // On a tie the requester not served last time wins.
                    winner         = (REQ0 && REQ1) ? ~last : REQ1;
                    shreg_next     = winner ? DATA1 : DATA0;
                    acc_next       = 1'b0;
                    cnt_next       = '0;
                    owner_int_next = winner;
                    last_next      = winner;
                    gnt0_next      = ~winner;
                    gnt1_next      = winner;
                end
            end
            S_RUN: begin
                acc_next   = bit_f;
                shreg_next = shreg >> 1;
                cnt_next   = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    done_next  = 1'b1;
                    par_next   = bit_f;
                    owner_next = owner_int;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xor_parity_arbiter.sv
// tb/tb_xor_parity_arbiter.sv - scoreboard bench for xor_parity_arbiter with directed jobs
module tb_xor_parity_arbiter;

    typedef struct packed {
        logic par;
        logic owner;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic       REQ0;
    logic [7:0] DATA0;
    logic       REQ1;
    logic [7:0] DATA1;
    logic       GNT0;
    logic       GNT1;
    logic       BUSY;
    logic       DONE;
    logic       PAR;
    logic       OWNER;

    int   checks;
    int   fails;
    int   cyc;
    int   gnt_cyc;
    int   prev_gnt_cyc;
    bit   have_prev;
    bit   alt_mode;
    int   busy_len;
    int   done_count;
    logic gnt_q[$];
    exp_t exp_q[$];

    xor_parity_arbiter #(.W(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ0  (REQ0),
        .DATA0 (DATA0),
        .REQ1  (REQ1),
        .DATA1 (DATA1),
        .GNT0  (GNT0),
        .GNT1  (GNT1),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .PAR   (PAR),
        .OWNER (OWNER)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops expected grants and results whenever the DUT presents them.
    always @(negedge CLK) begin
        if (RST) begin
            busy_len  = 0;
            have_prev = 1'b0;
        end else begin
            if (GNT0 || GNT1) begin
                check("gnt_exclusive", int'(GNT0 & GNT1), 0);
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 1, 0);
                end else begin
                    check("gnt_index", int'(GNT1), int'(gnt_q.pop_front()));
                end
                if (alt_mode && have_prev) check("gnt_gap", cyc - prev_gnt_cyc, 10);
                prev_gnt_cyc = cyc;
                have_prev    = alt_mode;
                gnt_cyc      = cyc;
            end
            if (DONE) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("par", int'(PAR), int'(e.par));
                    check("owner", int'(OWNER), int'(e.owner));
                    check("done_latency", cyc - gnt_cyc, 8);
                end
            end
            if (BUSY) begin
                busy_len++;
            end else if (busy_len != 0) begin
                check("busy_len", busy_len, 9);
                busy_len = 0;
            end
        end
    end

    task automatic wait_gnt(input bit idx);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge CLK);
            #1;
            if ((idx ? GNT1 : GNT0) === 1'b1) found = 1'b1;
        end
        check("gnt_timeout", int'(found), 1);
    endtask

    task automatic wait_done();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) found = 1'b1;
        end
        check("done_timeout", int'(found), 1);
    endtask

    task automatic job(input bit idx, input logic [7:0] d, input bit p, input bit hold);
        gnt_q.push_back(idx);
        exp_q.push_back('{par: p, owner: idx});
        if (idx) begin
            DATA1 = d;
            REQ1  = 1'b1;
        end else begin
            DATA0 = d;
            REQ0  = 1'b1;
        end
        wait_gnt(idx);
        if (!hold) begin
            if (idx) REQ1 = 1'b0;
            else     REQ0 = 1'b0;
        end
        wait_done();
        if (idx) REQ1 = 1'b0;
        else     REQ0 = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_outs", int'({GNT0, GNT1, BUSY, DONE, PAR, OWNER}), 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int dc;
        checks = 0; fails = 0; cyc = 0; gnt_cyc = 0; prev_gnt_cyc = 0;
        have_prev = 1'b0; alt_mode = 1'b0; busy_len = 0; done_count = 0;
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; DATA0 = '0; DATA1 = '0;
        repeat (2) @(posedge CLK);
        #1;
        pulse_reset();

        job(1'b0, 8'hA5, 1'b0, 1'b0);
        job(1'b1, 8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        check("par_owner_hold", int'({PAR, OWNER}), 3);

        job(1'b0, 8'h00, 1'b0, 1'b0);
        job(1'b0, 8'h80, 1'b1, 1'b0);
        job(1'b0, 8'h0B, 1'b1, 1'b1);

        // Abort a job with reset three cycles into RUN.
        gnt_q.push_back(1'b0);
        DATA0 = 8'hA5;
        REQ0  = 1'b1;
        wait_gnt(1'b0);
        REQ0 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        dc = done_count;
        pulse_reset();
        repeat (12) @(posedge CLK);
        #1;
        check("no_done_after_abort", done_count, dc);
        job(1'b0, 8'h1C, 1'b1, 1'b0);

        // Both requesters held continuously: grants must alternate 0,1,0,1.
        pulse_reset();
        alt_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back(k[0]);
            exp_q.push_back('{par: k[0], owner: k[0]});
        end
        DATA0 = 8'hFF;
        DATA1 = 8'h01;
        REQ0  = 1'b1;
        REQ1  = 1'b1;
        for (int k = 0; k < 4; k++) wait_done();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        alt_mode = 1'b0;

        check("gnt_queue_empty", gnt_q.size(), 0);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/xor_parity_arbiter.md
XOR_PARITY_ARBITER -- requirements
Module: xor_parity_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data word width in bits (legal range 2..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port REQ0, input, 1 bit: requester 0 job request, held high until GNT0 is seen.
REQ-005 The block SHALL have port DATA0, input, W bits: requester 0 word, stable while REQ0 is high.
REQ-006 The block SHALL have port REQ1, input, 1 bit: requester 1 job request, same rules as REQ0.
REQ-007 The block SHALL have port DATA1, input, W bits: requester 1 word, same rules as DATA0.
REQ-008 The block SHALL have port GNT0, output, 1 bit: one-cycle pulse meaning DATA0 has been captured.
REQ-009 The block SHALL have port GNT1, output, 1 bit: one-cycle pulse meaning DATA1 has been captured.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while a job is in RUN or DONE.
REQ-011 The block SHALL have port DONE, output, 1 bit: one-cycle pulse meaning PAR and OWNER are valid.
REQ-012 The block SHALL have port PAR, output, 1 bit: XOR of all W bits of the served word (1 = odd number of ones).
REQ-013 The block SHALL have port OWNER, output, 1 bit: index of the requester whose result is on PAR.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE, all outputs registered.
REQ-015 In IDLE with no request, the block SHALL remain in IDLE.
REQ-016 In IDLE with any REQ high, the block SHALL at the next edge:
- pick the winner;
- capture that requester's DATA into a W-bit shift register;
- clear the accumulator and bit counter;
- set the internal owner;
- pulse the winner's GNT high for the following cycle;
- enter RUN.
REQ-017 Winner selection SHALL be:
- only one REQ high: that requester wins;
- both REQ high: the requester not equal to LAST wins;
- LAST updates to the winner at each grant.
REQ-018 In RUN, each edge SHALL:
- XOR the shift register LSB into the accumulator;
- shift the register right by one;
- increment the counter.
REQ-019 RUN SHALL last exactly W cycles; at the edge where the counter equals W-1 the FSM SHALL go to DONE.
REQ-020 In DONE, the block SHALL drive DONE=1 for exactly one cycle, with PAR = final accumulator and OWNER = winner.
REQ-021 From DONE, the FSM SHALL return to IDLE unconditionally.
REQ-022 DONE SHALL rise exactly W cycles after the corresponding GNT rises, giving a throughput of one job per W+2 cycles.
REQ-023 PAR and OWNER SHALL hold their values after DONE until the next DONE.
REQ-024 The block SHALL ignore REQ inputs while in RUN or DONE; a REQ still high during the GNT cycle SHALL NOT produce a second grant.
REQ-025 GNT0 and GNT1 SHALL never be high in the same cycle.
REQ-026 The block SHALL never pulse DONE without a prior grant.

Reset
REQ-027 On RST high, the block SHALL immediately (asynchronously) force:
- state = IDLE;
- GNT0 = GNT1 = BUSY = DONE = PAR = OWNER = 0;
- accumulator, counter and shift register = 0;
- LAST = 1, so REQ0 wins the first tie.
REQ-028 RST asserted during RUN or DONE SHALL abort the job with no DONE pulse; requesters must re-request.
REQ-029 After RST deasserts, the first edge with a REQ high SHALL grant per REQ-016.

Structure
REQ-030 Shared package xor_arb_pkg SHALL hold the FSM state type (IDLE, RUN, DONE) and the default width constant (8).
REQ-031 The per-bit combine SHALL be the sub-module xor_bit_cell (inputs A, B; output F; F = A xor B), instantiated once and fed by the accumulator and the shift register LSB.
REQ-032 Counter width SHALL be the minimum that holds W-1.

Verification (W=8)
REQ-033 Scenario 1: REQ0=1, DATA0=8'hA5, REQ1=0 -> GNT0 pulse; DONE 8 cycles later; PAR=0, OWNER=0.
REQ-034 Scenario 2: REQ1=1, DATA1=8'h07 -> GNT1 pulse; DONE with PAR=1, OWNER=1; PAR/OWNER held afterward.
REQ-035 Scenario 3: from reset, REQ0 and REQ1 both held high continuously, DATA0=8'hFF, DATA1=8'h01 -> grants alternate 0,1,0,1 every 10 cycles; PAR alternates 0,1.
REQ-036 Scenario 4: RST pulsed 3 cycles into RUN -> no DONE; all outputs 0; a fresh REQ0 then completes normally.
REQ-037 Scenario 5: REQ0 held high through its GNT cycle and RUN -> exactly one GNT0 per job; BUSY high for 9 cycles per job.
REQ-038 Scenario 6: DATA0=8'h00 and 8'h80 -> PAR=0 and PAR=1, confirming the MSB is processed last.
